// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter
//   Shares one 128-bit AES block-encrypt core among NREQ requesters. Requests are
//   arbitrated round-robin, one block per grant is launched through the core's
//   start/done handshake, and the result goes back to the granted requester. A
//   watchdog aborts a block the core never completes and returns an error response.
//
// Ports
//   clk        : clock, rising edge
//   g_rst_n    : asynchronous active-low reset (shared with the AES core)
//   req_valid  : per-requester block pending
//   req_data   : requester i block at [i*128 +: 128]
//   req_ready  : one-hot accept strobe (IDLE only)
//   rsp_valid  : one-hot result valid, held until rsp_ready of the granted requester
//   rsp_ready  : per-requester result consume
//   rsp_data   : shared result bus, qualified by rsp_valid
//   rsp_err    : 1 = watchdog timeout (rsp_data = 0)
//   aes_start  : one-cycle start pulse to the core
//   aes_din    : block to the core, stable from aes_start until done/abort
//   aes_done   : core completion pulse
//   aes_dout   : core result, valid with aes_done
//   busy       : high in every state except IDLE

module aes_req_arbiter #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                g_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*128-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [127:0]        rsp_data,
  output logic                rsp_err,
  output logic                aes_start,
  output logic [127:0]        aes_din,
  input  logic                aes_done,
  input  logic [127:0]        aes_dout,
  output logic                busy
);

  localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [127:0]        din_q, din_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [127:0]        rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                arb_found;
  logic [IdxW-1:0]     arb_idx;
  logic [IdxW:0]       arb_sum;

  // Round-robin pick: first pending index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (arb_sum >= (IdxW+1)'(NREQ)) begin
        arb_sum = arb_sum - (IdxW+1)'(NREQ);
      end
      if (!arb_found && req_valid[arb_sum[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    din_d       = din_q;
    timer_d     = timer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    aes_start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          req_ready[arb_idx] = 1'b1;
          gnt_d              = arb_idx;
          din_d              = req_data[arb_idx*128 +: 128];
          state_d            = StStart;
        end
      end
      StStart: begin
        aes_start = 1'b1;
        timer_d   = '0;
        state_d   = StWait;
      end
      StWait: begin
        // A done on the final timeout cycle still counts as a completion.
        if (aes_done) begin
          rsp_data_d         = aes_dout;
          rsp_err_d          = 1'b0;
          rsp_valid_d        = '0;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = StResp;
        end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
          rsp_data_d         = '0;
          rsp_err_d          = 1'b1;
          rsp_valid_d        = '0;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (gnt_q == IdxW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      din_q       <= '0;
      timer_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      din_q       <= din_d;
      timer_q     <= timer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign aes_din   = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

endmodule
